// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//   Round-robin scanner for a 4:1 single-bit mux. Steps the mux select over
//   the enabled channels, holding each for DWELL cycles. SETTLE cycles after
//   each select update it samples the mux output into a single-entry buffer.
//   The buffer is presented to a consumer on a valid/ready port.
//
// Parameters
//   DWELL   cycles sel stays on one channel (2..255)
//   SETTLE  cycles after a sel update before mux_in is sampled (1..DWELL-1)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   en         in   scan enable, looked at in IDLE and at each channel advance
//   ch_mask    in   [3:0] channel i is scanned when bit i is set
//   mux_in     in   output of the 4:1 mux
//   sel        out  [1:0] registered mux select
//   smp_valid  out  buffer holds a sample
//   smp_ready  in   consumer accepts when smp_valid & smp_ready
//   smp_data   out  sampled mux value
//   smp_ch     out  [1:0] channel the sample was taken on
//   busy       out  block is scanning
//   overrun    out  sticky: a sample was dropped because the buffer was full
module mux_scan_sequencer #(
  parameter int unsigned DWELL  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] ch_mask,
  input  logic       mux_in,
  output logic [1:0] sel,
  output logic       smp_valid,
  input  logic       smp_ready,
  output logic       smp_data,
  output logic [1:0] smp_ch,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned CH_W  = 2;
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(DWELL - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  typedef struct packed {
    logic            data;
    logic [CH_W-1:0] ch;
  } sample_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CH_W-1:0]  sel_d;
  sample_t          smp_buf, smp_buf_d;
  logic             valid_d;
  logic             overrun_d;
  logic             capture;
  logic             xfer;

  // Lowest-index set bit of the mask; 0 when the mask is empty.
  function automatic logic [CH_W-1:0] lowest_ch(input logic [3:0] mask);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) r = CH_W'(i);
    end
    return r;
  endfunction

  // First enabled channel searching upward from cur+1, wrapping; offset 4
  // lands back on cur so a lone enabled channel re-selects itself.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] cur,
                                              input logic [3:0]      mask);
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] c;
    r = cur;
    for (int i = 4; i >= 1; i--) begin
      c = cur + CH_W'(i);
      if (mask[c]) r = c;
    end
    return r;
  endfunction

  // Next-state, dwell counter and output-buffer logic.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    sel_d     = sel;
    smp_buf_d = smp_buf;
    valid_d   = smp_valid;
    overrun_d = overrun;
    capture   = 1'b0;
    xfer      = smp_valid & smp_ready;

    case (state)
      IDLE: begin
        if (en && (ch_mask != 4'b0000)) begin
          state_d = SCAN;
          sel_d   = lowest_ch(ch_mask);
          cnt_d   = '0;
        end
      end
      SCAN: begin
        capture = (cnt == SETTLE_CNT);
        if (cnt == LAST_CNT) begin
          cnt_d = '0;
          if (en && (ch_mask != 4'b0000)) begin
            sel_d = next_ch(sel, ch_mask);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A full buffer only takes a new sample when it drains on the same edge.
    if (capture) begin
      if (!smp_valid || xfer) begin
        smp_buf_d.data = mux_in;
        smp_buf_d.ch   = sel;
        valid_d        = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= '0;
      smp_buf   <= '0;
      smp_valid <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      sel       <= sel_d;
      smp_buf   <= smp_buf_d;
      smp_valid <= valid_d;
      overrun   <= overrun_d;
      busy      <= (state_d == SCAN);
    end
  end

  assign smp_data = smp_buf.data;
  assign smp_ch   = smp_buf.ch;

endmodule
